// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Line errors (framing, overrun) are held in sticky flags until CLR_I.
module uart_rx_fifo #(
  parameter int FREQ  = 12000000,
  parameter int BAUD  = 115200,
  parameter int DEPTH = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     RX_I,
  output logic [7:0]               DATA_O,
  output logic                     VALID_O,
  input  logic                     RD_I,
  output logic [$clog2(DEPTH):0]   COUNT_O,
  output logic                     FERR_O,
  output logic                     OVR_O,
  input  logic                     CLR_I
);

  localparam int CPB = FREQ / BAUD;
  localparam int TW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CPB / 2 - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rx_m;
  logic            rx_s;
  logic [TW-1:0]   timer;
  logic            tick;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            push;
  logic            ferr_set;

  logic [7:0]      mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;
  logic            ovr_set;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX_I;
      rx_s <= rx_m;
    end
  end

  assign tick = (timer == '0);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
    if (state == STOP && tick) begin
      push     = rx_s;
      ferr_set = ~rx_s;
    end
  end

  // Timer is preloaded with the half-bit count while idle so START samples mid start bit.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        START: begin
          bit_idx <= '0;
          timer   <= tick ? FULL_LOAD : timer - TW'(1);
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            timer   <= FULL_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP:    timer <= tick ? FULL_LOAD : timer - TW'(1);
        default: timer <= HALF_LOAD;
      endcase
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_pop  = RD_I & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is not an overrun.
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + (AW + 1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      FERR_O <= 1'b0;
      OVR_O  <= 1'b0;
    end else begin
      if (ferr_set)   FERR_O <= 1'b1;
      else if (CLR_I) FERR_O <= 1'b0;
      if (ovr_set)    OVR_O  <= 1'b1;
      else if (CLR_I) OVR_O  <= 1'b0;
    end
  end

  assign DATA_O  = mem[rd_ptr[AW-1:0]];
  assign VALID_O = ~empty;
  assign COUNT_O = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed serial frames; a read monitor checks popped
// bytes against an expected queue, and directed checks cover flags and counts.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [3:0] count;
  logic       ferr;
  logic       ovr;

  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  uart_rx_fifo #(.FREQ(12000000), .BAUD(115200), .DEPTH(8)) dut (
    .CLK_I(clk), .RST_I(rst), .RX_I(rx), .DATA_O(data), .VALID_O(valid),
    .RD_I(rd), .COUNT_O(count), .FERR_O(ferr), .OVR_O(ovr), .CLR_I(clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Read monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd && valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL read_unexpected: got %02h, required no byte", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          n_err++;
          $display("FAIL read_data: got %02h, required %02h", data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop);
  endtask

  task automatic read_one();
    rd = 1'b1;
    cycles(1);
    rd = 1'b0;
  endtask

  initial begin
    logic [2:0] st;
    bit         hit;
    cycles(3);
    check("reset_data", data, 0);
    check("reset_valid", valid, 0);
    check("reset_count", count, 0);
    check("reset_flags", {ferr, ovr}, 0);
    rst = 1'b0;
    cycles(5);

    // Single byte
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check("t1_valid", valid, 1);
    check("t1_count", count, 1);
    check("t1_ferr", ferr, 0);
    check("t1_head", data, 8'h55);
    read_one();
    check("t1_empty", valid, 0);

    // Back-to-back frames, then drain in order
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hA5);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    check("t2_count3", count, 3);
    read_one(); check("t2_count2", count, 2);
    read_one(); check("t2_count1", count, 1);
    read_one(); check("t2_count0", count, 0);
    check("t2_valid", valid, 0);

    // Overflow: nine bytes into eight slots
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    check("t3_count", count, 8);
    check("t3_ovr", ovr, 1);
    for (int i = 0; i < 8; i++) read_one();
    check("t3_drained", valid, 0);
    clr = 1'b1; cycles(1); clr = 1'b0; cycles(1);
    check("t3_ovr_clr", ovr, 0);

    // Framing error followed by a break, then a good byte
    send_frame(8'h3C, 1'b0);
    rx = 1'b0; cycles(5 * CPB);
    rx = 1'b1; cycles(CPB);
    check("t4_ferr", ferr, 1);
    check("t4_no_byte", count, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    check("t4_count", count, 1);
    check("t4_head", data, 8'h81);
    read_one();

    // Short glitch on an idle line
    rx = 1'b0; cycles(30);
    rx = 1'b1; cycles(200);
    st = dut.state;
    check("t5_state_idle", st, 0);
    check("t5_valid", valid, 0);

    // Full FIFO with a pop in the stop-bit sample cycle of a ninth byte
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h11 + 8'(i));
      send_frame(8'h11 + 8'(i), 1'b1);
    end
    check("t6_full", count, 8);
    exp_q.push_back(8'h99);
    hit = 1'b0;
    fork
      send_frame(8'h99, 1'b1);
      begin
        for (int i = 0; i < 1100 && !hit; i++) begin
          cycles(1);
          if (dut.state == 3'd3 && dut.timer == '0) begin
            hit = 1'b1;
            rd = 1'b1;
            cycles(1);
            rd = 1'b0;
          end
        end
      end
    join
    check("t6_stop_found", hit, 1);
    check("t6_ovr", ovr, 0);
    check("t6_count", count, 8);
    for (int i = 0; i < 8; i++) read_one();
    check("t6_drained", valid, 0);

    // Reset in the middle of a frame, with a byte stored and FERR still set
    send_frame(8'h42, 1'b1);
    rx = 1'b0; cycles(300);
    rst = 1'b1; cycles(2);
    check("t7_data", data, 0);
    check("t7_valid", valid, 0);
    check("t7_count", count, 0);
    check("t7_ferr", ferr, 0);
    check("t7_ovr", ovr, 0);
    rst = 1'b0; cycles(50);
    rx = 1'b1; cycles(12 * CPB);

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver with a receive FIFO, clocked from the system clock. Serial data enters on the line driven by the UART stimulus model in simulation, or by the board pin in hardware. Bytes are delivered to the CPU-side peripheral register logic through a first-word-fall-through read port. Line errors are recorded in sticky flags for software to read.

Parameters:
FREQ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = FREQ/BAUD (integer division, 104 at defaults)
DEPTH, 8, FIFO entries; power of two, minimum 2

Ports:
CLK_I  input  1  system clock; all logic on rising edge
RST_I  input  1  asynchronous, active-high reset
RX_I  input  1  serial line, idle high, asynchronous to CLK_I
DATA_O  output  8  FIFO head byte; valid only while VALID_O=1
VALID_O  output  1  FIFO not empty
RD_I  input  1  pop the head entry; ignored when VALID_O=0
COUNT_O  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
FERR_O  output  1  sticky framing error
OVR_O  output  1  sticky overrun
CLR_I  input  1  clears FERR_O and OVR_O

Behaviour:
- Reset (async assert, sync release): synchronizer flops = 1; FSM = IDLE; FIFO pointers = 0.
- Output values during reset: DATA_O=0, VALID_O=0, COUNT_O=0, FERR_O=0, OVR_O=0.
- RX_I passes through a 2-flop synchronizer. rx_s denotes the second flop's output. All line decisions use rx_s only.
- The bit timer counts 0..CLKS_PER_BIT-1. A sample point is the cycle in which the timer reaches its terminal value.
- IDLE: on rx_s=0, go to START and load the timer for CLKS_PER_BIT/2 cycles.
- START: at the half-bit point:
  - rx_s=0: go to DATA with bit index 0 and a full-bit timer.
  - rx_s=1: treat as a glitch and return to IDLE; nothing is stored.
- DATA: at each full-bit point, shift rx_s in LSB-first. After bit index 7 is sampled, go to STOP.
- STOP: at the full-bit point:
  - rx_s=1: push the byte to the FIFO and go to IDLE.
  - rx_s=0: discard the byte, set FERR_O, and go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. A break condition (line held low) must not produce repeated bytes.
- Push timing:
  - The push happens in the stop-bit sample cycle.
  - VALID_O and COUNT_O update on the next clock edge.
  - Total latency from the middle of the stop bit at the pin: about 2 sync cycles + 1.
- FIFO behaviour:
  - Circular buffer with DEPTH entries, read/write pointers one bit wider than the address, and wrap-around at DEPTH.
  - DATA_O = mem[rd_ptr]; it is combinational from the registered memory and pointer.
  - Pop: RD_I=1 with VALID_O=1 advances rd_ptr on that edge.
  - Push and pop in the same cycle while non-empty and non-full: both occur, and COUNT_O is unchanged.
  - Push while full with a simultaneous valid pop: both occur, no overrun.
  - Push while full without a pop: the byte is dropped, OVR_O is set, and existing contents are unchanged.
  - Push while empty with RD_I=1: the pop is ignored and the push occurs.
- Sticky flags:
  - CLR_I clears both flags on the next edge.
  - If a set event and CLR_I coincide, set wins.
- Reset mid-frame aborts the frame immediately. After release, a line still low lands in START. It is either rejected at the half-bit check or yields a byte whose validity depends on timing. Software must discard traffic received within one frame of reset.
- No parity; 8N1 only. The FSM never stalls on a full FIFO; reception continues.

Test Plan:
- Send 0x55 at 104 clk/bit → exactly one push, DATA_O=0x55, VALID_O=1, COUNT_O=1, FERR_O=0.
- Send 0x00, 0xFF, 0xA5 back-to-back (one stop bit each), then pop three times → read order 0x00, 0xFF, 0xA5; COUNT_O goes 3,2,1,0; VALID_O=0 at the end.
- Send DEPTH+1=9 bytes 0x01..0x09 with no reads → COUNT_O=8, OVR_O=1; reads return 0x01..0x08. CLR_I pulse → OVR_O=0.
- Send 0x3C with the stop bit forced low, line low for a further 5 bit times, then high, then 0x81 → first byte discarded, FERR_O=1, no byte during break, COUNT_O=1, DATA_O=0x81.
- 30-cycle low glitch on an idle line → no push, FSM back in IDLE, VALID_O=0.
- FIFO full (8 entries); assert RD_I in the stop-bit cycle of a 9th byte 0x99 → OVR_O stays 0, COUNT_O stays 8, 0x99 is the last entry read. Then assert RST_I mid-frame → all outputs 0 within the reset assertion.
